// File: rtl/pc_redirect_fetch.sv
// Fetch stage: owns the PC, reads instruction memory under busywait, applies branch redirects and flushes.
// Optional PCFETCH_MISALIGN_TRAP_EN sends misaligned redirect targets to TRAP_VECTOR and adds MISALIGNED.
module pc_redirect_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
`ifdef PCFETCH_MISALIGN_TRAP_EN
    , parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
`endif
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PC_MUX,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        STALL,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_READ,
    input  logic        IMEM_BUSYWAIT,
    input  logic [31:0] IMEM_INSTR,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_INSTR,
    output logic        IF_VALID,
    output logic        FLUSH
`ifdef PCFETCH_MISALIGN_TRAP_EN
    , output logic      MISALIGNED
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        HOLD  = 2'b01,
        DRAIN = 2'b10
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] pend_r, pend_s;
    logic [31:0] skid_pc_r, skid_pc_s;
    logic [31:0] skid_instr_r, skid_instr_s;
    logic [31:0] if_pc_r, if_pc_s;
    logic [31:0] if_instr_r, if_instr_s;
    logic        if_valid_r, if_valid_s;
    logic        read_r, read_s;
    logic        flush_r, flush_s;
    logic [2:0]  flush_cnt_r, flush_cnt_s;
    logic        complete_s;
    logic [31:0] target_s;
`ifdef PCFETCH_MISALIGN_TRAP_EN
    logic        mis_r, mis_s;
`endif

    // Redirect target sanitising: trap on misalignment, or drop the low bits
    always_comb begin
`ifdef PCFETCH_MISALIGN_TRAP_EN
        mis_s = 1'b0;
        if (BRANCH_TARGET[1:0] != 2'b00) begin
            target_s = TRAP_VECTOR;
            mis_s    = PC_MUX;
        end else begin
            target_s = BRANCH_TARGET;
        end
`else
        target_s = BRANCH_TARGET & 32'hFFFF_FFFC;
`endif
    end

    // Next-state and next-output logic for the fetch FSM
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        pend_s       = pend_r;
        skid_pc_s    = skid_pc_r;
        skid_instr_s = skid_instr_r;
        if_pc_s      = if_pc_r;
        if_instr_s   = if_instr_r;
        if_valid_s   = if_valid_r;
        complete_s   = read_r & ~IMEM_BUSYWAIT;

        if (flush_cnt_r != 3'd0) begin
            flush_cnt_s = flush_cnt_r - 3'd1;
            flush_s     = 1'b1;
        end else begin
            flush_cnt_s = flush_cnt_r;
            flush_s     = 1'b0;
        end

        if (PC_MUX) begin
            flush_s     = 1'b1;
            flush_cnt_s = FLUSH_RELOAD;
            if_valid_s  = 1'b0;
            if_instr_s  = NOP_INSTR;
            // A read still in flight must finish at its old address before the PC can move
            if (read_r && IMEM_BUSYWAIT) begin
                pend_s  = target_s;
                state_s = DRAIN;
            end else begin
                pc_s    = target_s;
                state_s = FETCH;
            end
        end else begin
            case (state_r)
                FETCH: begin
                    if (complete_s) begin
                        pc_s = pc_r + 32'd4;
                        if (STALL) begin
                            skid_pc_s    = pc_r;
                            skid_instr_s = IMEM_INSTR;
                            state_s      = HOLD;
                        end else begin
                            if_pc_s    = pc_r;
                            if_instr_s = IMEM_INSTR;
                            if_valid_s = 1'b1;
                        end
                    end else if (!STALL) begin
                        if_valid_s = 1'b0;
                        if_instr_s = NOP_INSTR;
                    end else begin
                        state_s = FETCH;
                    end
                end
                HOLD: begin
                    if (!STALL) begin
                        if_pc_s    = skid_pc_r;
                        if_instr_s = skid_instr_r;
                        if_valid_s = 1'b1;
                        state_s    = FETCH;
                    end else begin
                        state_s = HOLD;
                    end
                end
                DRAIN: begin
                    if (complete_s) begin
                        pc_s    = pend_r;
                        state_s = FETCH;
                    end else begin
                        state_s = DRAIN;
                    end
                end
                default: begin
                    state_s = FETCH;
                end
            endcase
        end

        read_s = (state_s != HOLD);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r      <= FETCH;
            pc_r         <= RESET_VECTOR;
            pend_r       <= 32'h0000_0000;
            skid_pc_r    <= 32'h0000_0000;
            skid_instr_r <= 32'h0000_0000;
            if_pc_r      <= 32'h0000_0000;
            if_instr_r   <= NOP_INSTR;
            if_valid_r   <= 1'b0;
            read_r       <= 1'b0;
            flush_r      <= 1'b0;
            flush_cnt_r  <= 3'd0;
`ifdef PCFETCH_MISALIGN_TRAP_EN
            mis_r        <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            pend_r       <= pend_s;
            skid_pc_r    <= skid_pc_s;
            skid_instr_r <= skid_instr_s;
            if_pc_r      <= if_pc_s;
            if_instr_r   <= if_instr_s;
            if_valid_r   <= if_valid_s;
            read_r       <= read_s;
            flush_r      <= flush_s;
            flush_cnt_r  <= flush_cnt_s;
`ifdef PCFETCH_MISALIGN_TRAP_EN
            mis_r        <= mis_s;
`endif
        end
    end

    // In DRAIN pc_r still holds the abandoned address, so IMEM_ADDR is always pc_r
    assign IMEM_ADDR = pc_r;
    assign IMEM_READ = read_r;
    assign IF_PC     = if_pc_r;
    assign IF_INSTR  = if_instr_r;
    assign IF_VALID  = if_valid_r;
    assign FLUSH     = flush_r;
`ifdef PCFETCH_MISALIGN_TRAP_EN
    assign MISALIGNED = mis_r;
`endif

endmodule

// File: tb/tb_pc_redirect_fetch.sv
// Bench for pc_redirect_fetch: behavioural model compared every cycle, plus directed literal checks.
module tb_pc_redirect_fetch;

    localparam logic [31:0] RV   = 32'h0000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam int          FC   = 2;
    localparam logic [31:0] TRAP = 32'h0000_0100;

    logic        CLK = 1'b0;
    logic        RESET, PC_MUX, STALL, IMEM_BUSYWAIT;
    logic [31:0] BRANCH_TARGET;
    logic [31:0] IMEM_ADDR, IMEM_INSTR, IF_PC, IF_INSTR;
    logic        IMEM_READ, IF_VALID, FLUSH;
`ifdef PCFETCH_MISALIGN_TRAP_EN
    logic        MISALIGNED;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign IMEM_INSTR = instr_of(IMEM_ADDR);

    pc_redirect_fetch dut (
        .CLK(CLK), .RESET(RESET), .PC_MUX(PC_MUX), .BRANCH_TARGET(BRANCH_TARGET),
        .STALL(STALL), .IMEM_ADDR(IMEM_ADDR), .IMEM_READ(IMEM_READ),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .IMEM_INSTR(IMEM_INSTR), .IF_PC(IF_PC),
        .IF_INSTR(IF_INSTR), .IF_VALID(IF_VALID), .FLUSH(FLUSH)
`ifdef PCFETCH_MISALIGN_TRAP_EN
        , .MISALIGNED(MISALIGNED)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: expected outputs after each edge
    logic        m_ok = 1'b0;
    logic [31:0] m_pc, m_pend, m_skpc, m_skin, e_ifpc, e_ifin;
    logic        m_drain, m_skid, e_read, e_ifvalid, e_flush, e_mis;
    int          m_left;

    always @(posedge CLK) begin : model
        logic [31:0] tgt;
        logic        done, mis;
        done = e_read && !IMEM_BUSYWAIT;
        mis  = 1'b0;
`ifdef PCFETCH_MISALIGN_TRAP_EN
        if (BRANCH_TARGET[1:0] != 2'b00) begin
            tgt = TRAP;
            mis = 1'b1;
        end else begin
            tgt = BRANCH_TARGET;
        end
`else
        tgt = {BRANCH_TARGET[31:2], 2'b00};
`endif
        if (RESET) begin
            m_ok = 1'b1; m_pc = RV; m_drain = 1'b0; m_skid = 1'b0;
            e_read = 1'b0; e_ifvalid = 1'b0; e_ifin = NOP; e_ifpc = 32'h0;
            m_left = 0; e_flush = 1'b0; e_mis = 1'b0;
        end else begin
            e_mis = PC_MUX && mis;
            if (PC_MUX) begin
                m_left = FC; e_ifvalid = 1'b0; e_ifin = NOP; m_skid = 1'b0;
                if (e_read && IMEM_BUSYWAIT) begin
                    m_drain = 1'b1; m_pend = tgt;
                end else begin
                    m_drain = 1'b0; m_pc = tgt;
                end
            end else if (m_drain) begin
                if (done) begin
                    m_drain = 1'b0; m_pc = m_pend;
                end
            end else if (m_skid) begin
                if (!STALL) begin
                    e_ifpc = m_skpc; e_ifin = m_skin; e_ifvalid = 1'b1; m_skid = 1'b0;
                end
            end else if (done) begin
                if (STALL) begin
                    m_skpc = m_pc; m_skin = instr_of(m_pc); m_skid = 1'b1;
                end else begin
                    e_ifpc = m_pc; e_ifin = instr_of(m_pc); e_ifvalid = 1'b1;
                end
                m_pc = m_pc + 32'd4;
            end else if (!STALL) begin
                e_ifvalid = 1'b0; e_ifin = NOP;
            end
            e_flush = (m_left > 0);
            if (m_left > 0) m_left--;
            e_read = !m_skid;
        end
    end

    logic seen8 = 1'b0, seen12 = 1'b0, seen16 = 1'b0;

    // Per-cycle comparison against the model
    always @(negedge CLK) begin
        if (m_ok) begin
            check("imem_read", IMEM_READ, e_read);
            check("imem_addr", IMEM_ADDR, m_pc);
            check("if_valid", IF_VALID, e_ifvalid);
            check("if_instr", IF_INSTR, e_ifin);
            if (e_ifvalid) check("if_pc", IF_PC, e_ifpc);
            check("flush", FLUSH, e_flush);
`ifdef PCFETCH_MISALIGN_TRAP_EN
            check("misaligned", MISALIGNED, e_mis);
`endif
        end
        if (IF_VALID && IF_PC == 32'h8)  seen8  = 1'b1;
        if (IF_VALID && IF_PC == 32'hC)  seen12 = 1'b1;
        if (IF_VALID && IF_PC == 32'h10) seen16 = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1; PC_MUX = 1'b0; BRANCH_TARGET = 32'h0; STALL = 1'b0; IMEM_BUSYWAIT = 1'b0;
        tick(2);
        check("rst_read", IMEM_READ, 32'h0);
        check("rst_valid", IF_VALID, 32'h0);
        check("rst_instr", IF_INSTR, NOP);
        check("rst_flush", FLUSH, 32'h0);
        check("rst_addr", IMEM_ADDR, RV);
        RESET = 1'b0;
        tick(1);
        check("first_read", IMEM_READ, 32'h1);
        check("first_addr", IMEM_ADDR, 32'h0);
        check("pre_fetch_instr", IF_INSTR, NOP);
        tick(1);
        check("seq_addr4", IMEM_ADDR, 32'h4);
        check("seq_ifpc0", IF_PC, 32'h0);
        check("seq_valid", IF_VALID, 32'h1);
        check("seq_instr0", IF_INSTR, 32'hC0DE_0000);
        tick(1);
        check("seq_addr8", IMEM_ADDR, 32'h8);
        check("seq_ifpc4", IF_PC, 32'h4);
        // Redirect while fetching 8
        PC_MUX = 1'b1; BRANCH_TARGET = 32'h40;
        tick(1);
        check("redir_addr", IMEM_ADDR, 32'h40);
        check("redir_valid", IF_VALID, 32'h0);
        check("redir_flush1", FLUSH, 32'h1);
        PC_MUX = 1'b0;
        tick(1);
        check("redir_flush2", FLUSH, 32'h1);
        check("redir_ifpc", IF_PC, 32'h40);
        tick(1);
        check("redir_flush_end", FLUSH, 32'h0);
        // Drain: redirect while busy at 16
        PC_MUX = 1'b1; BRANCH_TARGET = 32'h10;
        tick(1);
        PC_MUX = 1'b0; IMEM_BUSYWAIT = 1'b1;
        tick(1);
        PC_MUX = 1'b1; BRANCH_TARGET = 32'h80;
        tick(1);
        check("drain_addr", IMEM_ADDR, 32'h10);
        check("drain_read", IMEM_READ, 32'h1);
        PC_MUX = 1'b0;
        tick(2);
        check("drain_addr_hold", IMEM_ADDR, 32'h10);
        IMEM_BUSYWAIT = 1'b0;
        tick(1);
        check("drain_done_addr", IMEM_ADDR, 32'h80);
        check("drain_discard", IF_VALID, 32'h0);
        tick(1);
        check("drain_ifpc", IF_PC, 32'h80);
        check("never_if16", seen16, 32'h0);
        check("never_if8_12", {seen8, seen12}, 32'h0);
        // Stall with completion into the skid
        STALL = 1'b1;
        tick(1);
        check("hold_read", IMEM_READ, 32'h0);
        check("hold_ifpc", IF_PC, 32'h80);
        tick(3);
        check("hold_ifpc_late", IF_PC, 32'h80);
        check("hold_instr_late", IF_INSTR, 32'hC0DE_0080);
        STALL = 1'b0;
        tick(1);
        check("skid_ifpc", IF_PC, 32'h84);
        check("skid_instr", IF_INSTR, 32'hC0DE_0084);
        check("skid_addr", IMEM_ADDR, 32'h88);
        tick(1);
        check("post_skid_ifpc", IF_PC, 32'h88);
        // PC wrap
        PC_MUX = 1'b1; BRANCH_TARGET = 32'hFFFF_FFFC;
        tick(1);
        check("wrap_pre", IMEM_ADDR, 32'hFFFF_FFFC);
        PC_MUX = 1'b0;
        tick(1);
        check("wrap_addr", IMEM_ADDR, 32'h0);
        // Reset during a drain
        IMEM_BUSYWAIT = 1'b1; PC_MUX = 1'b1; BRANCH_TARGET = 32'h200;
        tick(1);
        check("pre_rst_flush", FLUSH, 32'h1);
        PC_MUX = 1'b0; RESET = 1'b1;
        tick(1);
        check("midrst_read", IMEM_READ, 32'h0);
        check("midrst_addr", IMEM_ADDR, RV);
        check("midrst_flush", FLUSH, 32'h0);
        RESET = 1'b0; IMEM_BUSYWAIT = 1'b0;
        tick(2);
        // Misaligned redirect, then a second redirect restarting the flush count
        PC_MUX = 1'b1; BRANCH_TARGET = 32'h42;
        tick(1);
`ifdef PCFETCH_MISALIGN_TRAP_EN
        check("mis_addr", IMEM_ADDR, 32'h100);
        check("mis_pulse", MISALIGNED, 32'h1);
`else
        check("mis_addr", IMEM_ADDR, 32'h40);
`endif
        BRANCH_TARGET = 32'h300;
        tick(1);
`ifdef PCFETCH_MISALIGN_TRAP_EN
        check("mis_pulse_end", MISALIGNED, 32'h0);
`endif
        check("restart_addr", IMEM_ADDR, 32'h300);
        PC_MUX = 1'b0;
        tick(1);
        check("restart_flush", FLUSH, 32'h1);
        tick(1);
        check("restart_flush_end", FLUSH, 32'h0);
        // Mixed traffic; the compare process checks every cycle
        for (int i = 0; i < 300; i++) begin
            PC_MUX        = ($urandom_range(0, 7) == 0);
            BRANCH_TARGET = $urandom;
            STALL         = ($urandom_range(0, 2) == 0);
            IMEM_BUSYWAIT = ($urandom_range(0, 2) == 0);
            tick(1);
        end
        PC_MUX = 1'b0; STALL = 1'b0; IMEM_BUSYWAIT = 1'b0;
        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
